// File: rtl/iq_acc_pkg.sv
// ============================================================================
// Module   : iq_acc_pkg
// Brief    : Shared widths, FSM state type and {Q,I} packing for the I/Q
//            accumulator and the normalizer that consumes its output.
// Revision : 1.0
// ============================================================================
`default_nettype none

package iq_acc_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 32;
    localparam int LEN_W    = 16;

    localparam int I_LSB = 0;
    localparam int I_MSB = ACC_W - 1;
    localparam int Q_LSB = ACC_W;
    localparam int Q_MSB = 2 * ACC_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [2*ACC_W-1:0] pack_iq(input logic [ACC_W-1:0] acc_i,
                                                   input logic [ACC_W-1:0] acc_q);
        return {acc_q, acc_i};
    endfunction

endpackage

`default_nettype wire

// File: rtl/iq_acc_lane.sv
// ============================================================================
// Module   : iq_acc_lane
// Brief    : One signed accumulator lane (clear / enable / sign-extended add).
// Revision : 1.0
// ============================================================================
`default_nettype none

module iq_acc_lane #(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [ACC_W-1:0]    acc,
    output logic signed [ACC_W-1:0]    acc_nxt
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_sample_ext;

    assign w_sample_ext = {{(ACC_W - SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    // The top registers the final sum from acc_nxt, so no extra adder is needed.
    assign acc_nxt      = r_acc + w_sample_ext;
    assign acc          = r_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= acc_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/iq_accumulator.sv
// ============================================================================
// Module   : iq_accumulator
// Brief    : Integrates signed I/Q samples over a programmable window and
//            presents the packed {Q,I} sum with a one-cycle stb_start.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iq_accumulator #(
    parameter int SAMPLE_W = iq_acc_pkg::SAMPLE_W,
    parameter int ACC_W    = iq_acc_pkg::ACC_W,
    parameter int LEN_W    = iq_acc_pkg::LEN_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trig,
    input  logic [LEN_W-1:0]           window_len,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic signed [SAMPLE_W-1:0] sample_q,
    output logic [2*ACC_W-1:0]         accumulated_output,
    output logic                       stb_start,
    output logic                       busy,
    output logic                       retrig_err
);

    import iq_acc_pkg::*;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_cnt;
    logic [2*ACC_W-1:0]      r_out;
    logic                    r_retrig_err;
    logic                    w_accept;
    logic                    w_sample_en;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_acc_i;
    logic signed [ACC_W-1:0] w_acc_q;
    logic signed [ACC_W-1:0] w_nxt_i;
    logic signed [ACC_W-1:0] w_nxt_q;

    assign w_accept    = (r_state == IDLE) && trig && (window_len != '0);
    assign w_sample_en = (r_state == ACCUM) && sample_valid;
    assign w_last      = w_sample_en && (r_cnt == (r_len - LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stb_start   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                stb_start   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len        <= '0;
            r_cnt        <= '0;
            r_out        <= '0;
            r_retrig_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len <= window_len;
                r_cnt <= '0;
            end else if (w_sample_en) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
            if (w_last) begin
                r_out <= pack_iq(w_nxt_i, w_nxt_q);
            end
            // A trig outside IDLE never disturbs the running window; it only flags.
            if (trig && (r_state != IDLE)) begin
                r_retrig_err <= 1'b1;
            end
        end
    end

    iq_acc_lane #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W)
    ) u_lane_i (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_accept),
        .en      (w_sample_en),
        .sample  (sample_i),
        .acc     (w_acc_i),
        .acc_nxt (w_nxt_i)
    );

    iq_acc_lane #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W)
    ) u_lane_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_accept),
        .en      (w_sample_en),
        .sample  (sample_q),
        .acc     (w_acc_q),
        .acc_nxt (w_nxt_q)
    );

    assign accumulated_output = r_out;
    assign retrig_err         = r_retrig_err;

endmodule

`default_nettype wire

// File: tb/tb_iq_accumulator.sv
// ============================================================================
// Module   : tb_iq_accumulator
// Brief    : Directed self-checking bench for iq_accumulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iq_accumulator;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               trig;
    logic [15:0]        window_len;
    logic               sample_valid;
    logic signed [15:0] sample_i;
    logic signed [15:0] sample_q;
    logic [63:0]        accumulated_output;
    logic               stb_start;
    logic               busy;
    logic               retrig_err;

    int n_vec = 0;
    int n_err = 0;
    int n_stb = 0;
    int s0    = 0;

    always #5 clk = ~clk;

    iq_accumulator u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .trig               (trig),
        .window_len         (window_len),
        .sample_valid       (sample_valid),
        .sample_i           (sample_i),
        .sample_q           (sample_q),
        .accumulated_output (accumulated_output),
        .stb_start          (stb_start),
        .busy               (busy),
        .retrig_err         (retrig_err)
    );

    always @(negedge clk) begin
        if (stb_start) n_stb++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int len);
        trig       = 1'b1;
        window_len = 16'(len);
        tick();
        trig       = 1'b0;
    endtask

    task automatic smp(input int i, input int q);
        sample_valid = 1'b1;
        sample_i     = 16'(i);
        sample_q     = 16'(q);
        tick();
        sample_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; trig = 1'b0; window_len = '0;
        sample_valid = 1'b0; sample_i = '0; sample_q = '0;
        tick(); tick();
        check("rst_out",    accumulated_output, 64'd0);
        check("rst_stb",    64'(stb_start),     64'd0);
        check("rst_busy",   64'(busy),          64'd0);
        check("rst_retrig", 64'(retrig_err),    64'd0);
        rst_n = 1'b1;
        tick();

        // basic 4-sample window
        start(4);
        check("t1_busy", 64'(busy), 64'd1);
        smp(100, -1); smp(-50, -1); smp(25, -1);
        check("t1_early_stb", 64'(stb_start), 64'd0);
        smp(1, -1);
        check("t1_stb", 64'(stb_start), 64'd1);
        check("t1_out", accumulated_output, {32'hFFFFFFFC, 32'h0000004C});
        tick();
        check("t1_stb_off", 64'(stb_start), 64'd0);
        check("t1_idle",    64'(busy),      64'd0);
        check("t1_hold",    accumulated_output, {32'hFFFFFFFC, 32'h0000004C});

        // same window with idle gaps of 3, 0, 1, 2 cycles
        s0 = n_stb;
        start(4);
        tick(); tick(); tick();
        smp(100, -1); smp(-50, -1);
        tick();
        smp(25, -1);
        tick();
        check("t2_gap_stb", 64'(stb_start), 64'd0);
        tick();
        smp(1, -1);
        check("t2_stb", 64'(stb_start), 64'd1);
        check("t2_out", accumulated_output, {32'hFFFFFFFC, 32'h0000004C});
        tick();
        check("t2_nstb", 64'(n_stb - s0), 64'd1);

        // sample coincident with trig in IDLE is not counted
        trig = 1'b1; window_len = 16'd2;
        sample_valid = 1'b1; sample_i = 16'sd1000; sample_q = 16'sd1000;
        tick();
        trig = 1'b0; sample_valid = 1'b0;
        smp(1, 1); smp(2, -2);
        check("t3_stb", 64'(stb_start), 64'd1);
        check("t3_out", accumulated_output, {32'hFFFFFFFF, 32'h00000003});
        tick();

        // minimum latency: window_len=1, valid held high
        trig = 1'b1; window_len = 16'd1;
        sample_valid = 1'b1; sample_i = 16'sd9; sample_q = -16'sd9;
        tick();
        trig = 1'b0;
        check("t4_t1_stb", 64'(stb_start), 64'd0);
        tick();
        check("t4_stb", 64'(stb_start), 64'd1);
        check("t4_out", accumulated_output, {32'hFFFFFFF7, 32'h00000009});
        sample_valid = 1'b0;
        tick();

        // full-scale, longest window
        start(65535);
        sample_valid = 1'b1; sample_i = -16'sd32768; sample_q = 16'sd32767;
        repeat (65534) tick();
        check("t5_early_stb", 64'(stb_start), 64'd0);
        tick();
        sample_valid = 1'b0;
        check("t5_stb", 64'(stb_start), 64'd1);
        check("t5_out", accumulated_output, {32'h7FFE8001, 32'h80008000});
        tick();

        // retrigger in ACCUM and in DONE
        start(3);
        smp(10, 1); smp(20, 2);
        check("t6_noerr", 64'(retrig_err), 64'd0);
        trig = 1'b1; window_len = 16'd7;
        tick();
        trig = 1'b0;
        check("t6_err_accum", 64'(retrig_err), 64'd1);
        check("t6_busy",      64'(busy),       64'd1);
        s0 = n_stb;
        smp(30, 3);
        check("t6_stb", 64'(stb_start), 64'd1);
        check("t6_out", accumulated_output, {32'd6, 32'd60});
        trig = 1'b1; window_len = 16'd5;
        tick();
        trig = 1'b0;
        check("t6_done_idle", 64'(busy),       64'd0);
        check("t6_err_stuck", 64'(retrig_err), 64'd1);
        tick(); tick();
        check("t6_nstb", 64'(n_stb - s0), 64'd1);
        check("t6_hold", accumulated_output, {32'd6, 32'd60});

        // reset mid-window aborts it
        start(10);
        smp(1, 1);
        rst_n = 1'b0; sample_valid = 1'b1; sample_i = 16'sd2; sample_q = 16'sd2;
        tick();
        rst_n = 1'b1; sample_valid = 1'b0;
        check("t7_out",    accumulated_output, 64'd0);
        check("t7_busy",   64'(busy),          64'd0);
        check("t7_stb",    64'(stb_start),     64'd0);
        check("t7_retrig", 64'(retrig_err),    64'd0);
        s0 = n_stb;
        sample_valid = 1'b1;
        repeat (12) tick();
        sample_valid = 1'b0;
        check("t7_nostb", 64'(n_stb - s0), 64'd0);
        start(2);
        smp(5, -3); smp(7, 4);
        check("t7_stb2", 64'(stb_start), 64'd1);
        check("t7_out2", accumulated_output, {32'd1, 32'd12});
        tick();

        // zero-length trig is ignored
        s0 = n_stb;
        start(0);
        check("t8_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        check("t8_busy2",  64'(busy),        64'd0);
        check("t8_nostb",  64'(n_stb - s0),  64'd0);
        check("t8_retrig", 64'(retrig_err),  64'd0);
        check("t8_hold",   accumulated_output, {32'd1, 32'd12});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
